mul_div_unit: RTL and testbench

//  HI/LO multiply-divide unit in EX, consuming the decoder's is_mult/is_multu/is_div/is_divu/hi_wen/lo_wen.

---
 rtl/mul_div_unit.sv | 216 +++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : HI/LO multiply-divide unit (single-cycle multiply, iterative
//            restoring divide with sign-fix cycle). Optional macro
//            MDU_ITER_MUL_EN selects an iterative shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        flush,
  input  logic        is_mult,
  input  logic        is_multu,
  input  logic        is_div,
  input  logic        is_divu,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam int         c_ITER     = 32 / DIV_BITS_PER_CYCLE;
  localparam logic [5:0] c_ITER_CNT = 6'(c_ITER);

`ifdef MDU_ITER_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV_RUN = 2'd1, S_MUL_RUN = 2'd2, S_FIX = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV_RUN = 2'd1, S_FIX = 2'd3} state_t;
`endif

  state_t      r_state, w_state_nxt;
  logic [31:0] r_hi, r_lo, r_rem, r_quo, r_divisor;
  logic [5:0]  r_cnt;
  logic        r_busy, r_done, r_neg_q, r_neg_r, r_dz;

  // Fixed-priority decode: div > divu > mult > multu > mthi > mtlo
  logic w_op_div, w_op_divu, w_op_mult, w_op_multu, w_op_mthi, w_op_mtlo;
  logic w_any_op, w_accept, w_op_is_div, w_signed;
  logic [31:0] w_mag_a, w_mag_b;

  assign w_op_div    = is_div;
  assign w_op_divu   = ~is_div & is_divu;
  assign w_op_mult   = ~is_div & ~is_divu & is_mult;
  assign w_op_multu  = ~is_div & ~is_divu & ~is_mult & is_multu;
  assign w_op_mthi   = ~is_div & ~is_divu & ~is_mult & ~is_multu & hi_wen;
  assign w_op_mtlo   = ~is_div & ~is_divu & ~is_mult & ~is_multu & ~hi_wen & lo_wen;
  assign w_any_op    = is_div | is_divu | is_mult | is_multu | hi_wen | lo_wen;
  assign w_accept    = op_valid & ~r_busy & ~flush & w_any_op;
  assign w_op_is_div = w_op_div | w_op_divu;
  assign w_signed    = w_op_div | w_op_mult;
  assign w_mag_a     = (w_signed & rs_data[31]) ? (32'd0 - rs_data) : rs_data;
  assign w_mag_b     = (w_signed & rt_data[31]) ? (32'd0 - rt_data) : rt_data;

  // Dividend is shifted out of the quotient register's MSB as quotient bits enter its LSB
  logic [31:0] w_div_rem, w_div_quo;
  logic [32:0] w_div_trial;
  always_comb begin
    w_div_rem   = r_rem;
    w_div_quo   = r_quo;
    w_div_trial = '0;
    for (int s = 0; s < DIV_BITS_PER_CYCLE; s++) begin
      w_div_trial = {w_div_rem, w_div_quo[31]};
      w_div_quo   = {w_div_quo[30:0], 1'b0};
      if (w_div_trial >= {1'b0, r_divisor}) begin
        w_div_trial  = w_div_trial - {1'b0, r_divisor};
        w_div_quo[0] = 1'b1;
      end
      w_div_rem = w_div_trial[31:0];
    end
  end

  logic [31:0] w_fix_quo, w_fix_rem;
  assign w_fix_quo = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - r_quo) : r_quo);
  assign w_fix_rem = r_neg_r ? (32'd0 - r_rem) : r_rem;

`ifdef MDU_ITER_MUL_EN
  // Shift-add: {r_rem, r_quo} is {partial high word, remaining multiplier}
  logic        r_is_mul;
  logic        w_op_is_mul;
  logic [31:0] w_mul_acc, w_mul_mpl;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_prod;
  assign w_op_is_mul = w_op_mult | w_op_multu;
  assign w_mul_prod  = r_neg_q ? (64'd0 - {r_rem, r_quo}) : {r_rem, r_quo};
  always_comb begin
    w_mul_acc = r_rem;
    w_mul_mpl = r_quo;
    w_mul_sum = '0;
    for (int s = 0; s < DIV_BITS_PER_CYCLE; s++) begin
      w_mul_sum              = {1'b0, w_mul_acc} + (w_mul_mpl[0] ? {1'b0, r_divisor} : 33'd0);
      {w_mul_acc, w_mul_mpl} = {w_mul_sum, w_mul_mpl[31:1]};
    end
  end
`else
  logic [63:0] w_prod_s, w_prod_u;
  assign w_prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
  assign w_prod_u = {32'd0, rs_data} * {32'd0, rt_data};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_op_is_div) w_state_nxt = S_DIV_RUN;
`ifdef MDU_ITER_MUL_EN
        else if (w_accept && w_op_is_mul) w_state_nxt = S_MUL_RUN;
      end
      S_MUL_RUN: begin
        if (r_cnt == 6'd1) w_state_nxt = S_FIX;
`endif
      end
      S_DIV_RUN: begin
        if (r_cnt == 6'd1) w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
`ifdef MDU_ITER_MUL_EN
      r_is_mul  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept && w_op_is_div) begin
        r_rem     <= '0;
        r_quo     <= w_mag_a;
        r_divisor <= w_mag_b;
        r_cnt     <= c_ITER_CNT;
        r_neg_q   <= w_signed & (rs_data[31] ^ rt_data[31]);
        r_neg_r   <= w_signed & rs_data[31];
        r_dz      <= (rt_data == 32'd0);
`ifdef MDU_ITER_MUL_EN
        r_is_mul  <= 1'b0;
      end else if (w_accept && w_op_is_mul) begin
        r_rem     <= '0;
        r_quo     <= w_mag_a;
        r_divisor <= w_mag_b;
        r_cnt     <= c_ITER_CNT;
        r_neg_q   <= w_signed & (rs_data[31] ^ rt_data[31]);
        r_neg_r   <= 1'b0;
        r_dz      <= 1'b0;
        r_is_mul  <= 1'b1;
`else
      end else if (w_accept && w_op_mult) begin
        {r_hi, r_lo} <= w_prod_s;
        r_done       <= 1'b1;
      end else if (w_accept && w_op_multu) begin
        {r_hi, r_lo} <= w_prod_u;
        r_done       <= 1'b1;
`endif
      end else if (w_accept && w_op_mthi) begin
        r_hi <= rs_data;
      end else if (w_accept && w_op_mtlo) begin
        r_lo <= rs_data;
      end else if (flush) begin
        r_cnt <= '0;
      end else if (r_state == S_DIV_RUN) begin
        r_rem <= w_div_rem;
        r_quo <= w_div_quo;
        r_cnt <= r_cnt - 6'd1;
`ifdef MDU_ITER_MUL_EN
      end else if (r_state == S_MUL_RUN) begin
        r_rem <= w_mul_acc;
        r_quo <= w_mul_mpl;
        r_cnt <= r_cnt - 6'd1;
      end else if (r_state == S_FIX && r_is_mul) begin
        {r_hi, r_lo} <= w_mul_prod;
        r_done       <= 1'b1;
`endif
      end else if (r_state == S_FIX) begin
        r_lo   <= w_fix_quo;
        r_hi   <= w_fix_rem;
        r_done <= 1'b1;
      end
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Scoreboard bench for mul_div_unit (honours MDU_ITER_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  localparam int DBPC = 1;
  localparam int ITER = 32 / DBPC;
`ifdef MDU_ITER_MUL_EN
  localparam int MUL_BUSY = ITER + 1;
`else
  localparam int MUL_BUSY = 0;
`endif
  localparam int DIV_BUSY = ITER + 1;

  // flag vector order: {div, divu, mult, multu, mthi, mtlo}
  localparam logic [5:0] F_DIV = 6'b100000, F_DIVU = 6'b010000, F_MULT = 6'b001000;
  localparam logic [5:0] F_MULTU = 6'b000100, F_MTHI = 6'b000010, F_MTLO = 6'b000001;

  logic        clk = 1'b0;
  logic        reset, op_valid, flush;
  logic        is_mult, is_multu, is_div, is_divu, hi_wen, lo_wen;
  logic [31:0] rs_data, rt_data, hi, lo;
  logic        busy, done;

  always #5 clk = ~clk;

  mul_div_unit #(.DIV_BITS_PER_CYCLE(DBPC)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .flush(flush),
    .is_mult(is_mult), .is_multu(is_multu), .is_div(is_div), .is_divu(is_divu),
    .hi_wen(hi_wen), .lo_wen(lo_wen), .rs_data(rs_data), .rt_data(rt_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (f[5] || f[4]) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (f[5]) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      end
      return {a % b, a / b};
    end
    if (f[3]) begin
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return p;
    end
    p = {32'd0, a} * {32'd0, b};
    return p;
  endfunction

  task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    {is_div, is_divu, is_mult, is_multu, hi_wen, lo_wen} = f;
    rs_data  = a;
    rt_data  = b;
    op_valid = (f != 6'd0);
  endtask

  // Issue one op, hold it until busy drops, then check the busy length
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_busy);
    int nb;
    drive(f, a, b);
    if (f[5:2] != 4'd0) sb_q.push_back(exp);
    @(posedge clk); #1;
    nb = 0;
    while (busy && nb < 200) begin
      nb++;
      @(posedge clk); #1;
    end
    drive(6'd0, 32'd0, 32'd0);
    check({tag, "_busy"}, 64'(nb), 64'(exp_busy));
    @(posedge clk); #1;
    check({tag, "_hilo"}, {hi, lo}, exp);
    {m_hi, m_lo} = exp;
  endtask

  always @(negedge clk) begin : sb_monitor
    logic [63:0] e;
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_hilo", {hi, lo}, e);
      end
    end
  end

  initial begin
    int nb;
    logic [5:0]  f;
    logic [31:0] a, b;
    reset = 1'b1;
    flush = 1'b0;
    drive(6'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy_done", {busy, done}, 2'b00);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;

    run_op("mthi", F_MTHI, 32'h1234_5678, 32'd0, {32'h1234_5678, m_lo}, 0);
    run_op("mtlo", F_MTLO, 32'h9ABC_DEF0, 32'd0, {m_hi, 32'h9ABC_DEF0}, 0);
    run_op("mult", F_MULT, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, MUL_BUSY);
    run_op("multu", F_MULTU, 32'hFFFF_FFFE, 32'd3, {32'h0000_0002, 32'hFFFF_FFFA}, MUL_BUSY);
    run_op("div", F_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_BUSY);
    run_op("divu", F_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, DIV_BUSY);
    run_op("divu_z", F_DIVU, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, DIV_BUSY);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, DIV_BUSY);
    run_op("div_z", F_DIV, 32'hFFFF_FFF8, 32'd0, {32'hFFFF_FFF8, 32'hFFFF_FFFF}, DIV_BUSY);
    run_op("prio_div", F_DIV | F_MULT | F_MTHI | F_MTLO, 32'hFFFF_FFF9, 32'd2,
           {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_BUSY);
    run_op("prio_mult", F_MULT | F_MULTU | F_MTHI | F_MTLO, 32'hFFFF_FFFE, 32'd3,
           {32'hFFFF_FFFF, 32'hFFFF_FFFA}, MUL_BUSY);

    // Abort a divide at busy cycle 10
    drive(F_DIV, 32'd100, 32'd7);
    @(posedge clk); #1;
    nb = 0;
    while (busy && nb < 10) begin
      nb++;
      if (nb < 10) begin @(posedge clk); #1; end
    end
    check("flush_busy_seen", 64'(nb), 64'd10);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drive(6'd0, 32'd0, 32'd0);
    check("flush_busy", {63'd0, busy}, 64'd0);
    repeat (ITER + 4) @(posedge clk);
    #1;
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});
    run_op("div_after_flush", F_DIV, 32'd1000, 32'hFFFF_FFFD, {32'd1, 32'hFFFF_FEB3}, DIV_BUSY);

    // Flush coinciding with the accept edge
    drive(F_DIVU, 32'd9, 32'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drive(6'd0, 32'd0, 32'd0);
    check("flush_acc_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("flush_acc_hilo", {hi, lo}, {m_hi, m_lo});

    // Asynchronous reset during busy cycle 5
    drive(F_DIV, 32'd100, 32'd7);
    @(posedge clk); #1;
    nb = 0;
    while (busy && nb < 5) begin
      nb++;
      if (nb < 5) begin @(posedge clk); #1; end
    end
    check("rst_busy_seen", 64'(nb), 64'd5);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    drive(6'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;

    run_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, MUL_BUSY);

    for (int i = 0; i < 12; i++) begin
      f = 6'b100000 >> (i % 4);
      a = $urandom;
      b = (i == 5) ? 32'd0 : ((i % 3 == 0) ? ($urandom & 32'hFFFF) : $urandom);
      run_op("rand", f, a, b, model(f, a, b), (f[5] || f[4]) ? DIV_BUSY : MUL_BUSY);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
